stream_demux: RTL and testbench

Routes one valid/ready input stream to one of `N_OUT` output streams, chosen per beat by a select field. It is the demultiplexing counterpart of the team's mux primitives: each output owns a one-entry holding slot, so a stalled output does not block beats addressed to other outputs. It sits between a single producer and several independent consumers in the exercise datapaths.

---
 rtl/stream_demux_pkg.sv | 24 ++
 rtl/stream_demux_slot.sv | 69 ++++++
 rtl/stream_demux.sv | 98 +++++++++
 tb/tb_stream_demux.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/stream_demux_pkg.sv
// stream_demux_pkg: shared types and constants for the stream demultiplexer.
package stream_demux_pkg;

  // Occupancy of a per-channel one-entry holding slot.
  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_t;

  // Width of the optional discarded-beat counter.
  localparam int DROP_CNT_W = 16;

  // Saturating increment: holds at all-ones instead of wrapping.
  function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
    logic [DROP_CNT_W-1:0] r;
    if (v == {DROP_CNT_W{1'b1}}) begin
      r = v;
    end else begin
      r = v + {{(DROP_CNT_W-1){1'b0}}, 1'b1};
    end
    return r;
  endfunction

endpackage

// File: rtl/stream_demux_slot.sv
// stream_demux_slot: one-entry holding buffer for a single output channel.
// A push always wins over a pop, so a simultaneous pop+push keeps the slot
// full with the new payload and leaves no bubble.
module stream_demux_slot
  import stream_demux_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic [WIDTH-1:0] dout
);

  slot_state_t      state_r;
  slot_state_t      state_nxt_s;
  logic [WIDTH-1:0] data_r;

  // Next-state decode for the slot occupancy.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      SLOT_EMPTY: begin
        if (push) begin
          state_nxt_s = SLOT_FULL;
        end else begin
          state_nxt_s = SLOT_EMPTY;
        end
      end
      SLOT_FULL: begin
        if (push) begin
          state_nxt_s = SLOT_FULL;
        end else if (pop) begin
          state_nxt_s = SLOT_EMPTY;
        end else begin
          state_nxt_s = SLOT_FULL;
        end
      end
      default: state_nxt_s = SLOT_EMPTY;
    endcase
  end

  // Occupancy register; reset empties the slot at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= SLOT_EMPTY;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Payload register; only a push changes it, so data is stable while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_r <= '0;
    end else if (push) begin
      data_r <= din;
    end else begin
      data_r <= data_r;
    end
  end

  assign full = (state_r == SLOT_FULL);
  assign dout = data_r;

endmodule

// File: rtl/stream_demux.sv
// stream_demux: routes one valid/ready stream to N_OUT outputs by in_sel.
// Each output has its own one-entry slot so a stalled consumer blocks only
// beats addressed to it. Beats with an out-of-range select are accepted,
// discarded and flagged in the sticky sel_err.
// Optional build macro: STREAM_DEMUX_STATS_EN adds the saturating drop_cnt port.
module stream_demux
  import stream_demux_pkg::*;
#(
  parameter  int N_OUT = 4,
  parameter  int WIDTH = 8,
  localparam int SEL_W = $clog2(N_OUT)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [WIDTH-1:0]            in_data,
  input  logic [SEL_W-1:0]            in_sel,
  output logic [N_OUT-1:0]            out_valid,
  input  logic [N_OUT-1:0]            out_ready,
  output logic [N_OUT-1:0][WIDTH-1:0] out_data,
  output logic                        sel_err
`ifdef STREAM_DEMUX_STATS_EN
  ,
  output logic [DROP_CNT_W-1:0]       drop_cnt
`endif
);

  logic [N_OUT-1:0] hit_s;
  logic             legal_s;
  logic             in_ready_s;
  logic             drop_s;
  logic [N_OUT-1:0] push_s;
  logic [N_OUT-1:0] pop_s;
  logic [N_OUT-1:0] full_s;
  logic             sel_err_r;

  // Select decode and input acceptance. Decoding by equality against each
  // channel index keeps the range check free of out-of-bounds indexing.
  always_comb begin
    hit_s = '0;
    for (int i = 0; i < N_OUT; i++) begin
      hit_s[i] = (in_sel == SEL_W'(i));
    end
    legal_s    = |hit_s;
    in_ready_s = rst_n & (~legal_s | (|(hit_s & (~full_s | out_ready))));
    push_s     = {N_OUT{in_valid & in_ready_s}} & hit_s;
    pop_s      = full_s & out_ready;
    drop_s     = in_valid & in_ready_s & ~legal_s;
  end

  for (genvar g = 0; g < N_OUT; g++) begin : g_slot
    stream_demux_slot #(
      .WIDTH (WIDTH)
    ) u_slot (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push_s[g]),
      .pop   (pop_s[g]),
      .din   (in_data),
      .full  (full_s[g]),
      .dout  (out_data[g])
    );
  end

  // Sticky flag recording that an illegal-select beat was discarded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_err_r <= 1'b0;
    end else if (drop_s) begin
      sel_err_r <= 1'b1;
    end else begin
      sel_err_r <= sel_err_r;
    end
  end

`ifdef STREAM_DEMUX_STATS_EN
  logic [DROP_CNT_W-1:0] drop_cnt_r;

  // Saturating count of discarded beats.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt_r <= '0;
    end else if (drop_s) begin
      drop_cnt_r <= sat_inc(drop_cnt_r);
    end else begin
      drop_cnt_r <= drop_cnt_r;
    end
  end

  assign drop_cnt = drop_cnt_r;
`endif

  assign in_ready  = in_ready_s;
  assign out_valid = full_s;
  assign sel_err   = sel_err_r;

endmodule

// File: tb/tb_stream_demux.sv
// tb_stream_demux: drives a 4-channel and a 3-channel demux side by side and
// compares both against a per-channel occupancy model kept in the bench.
module tb_stream_demux;

  logic            clk;
  logic            rst_n;
  logic [7:0]      data;
  logic            va, vb;
  logic [1:0]      sa, sb;
  logic [3:0]      ra;
  logic [2:0]      rb;
  logic            ira, irb;
  logic [3:0]      ova;
  logic [2:0]      ovb;
  logic [3:0][7:0] oda;
  logic [2:0][7:0] odb;
  logic            erra, errb;
`ifdef STREAM_DEMUX_STATS_EN
  logic [15:0]     dca, dcb;
`endif

  int passes = 0;
  int total  = 0;

  // Reference model: [0] = 4-channel instance, [1] = 3-channel instance.
  bit         m_full [2][4];
  logic [7:0] m_data [2][4];
  bit         m_err  [2];
  int         m_drop [2];

  stream_demux #(.N_OUT(4), .WIDTH(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(va), .in_ready(ira), .in_data(data),
    .in_sel(sa), .out_valid(ova), .out_ready(ra), .out_data(oda), .sel_err(erra)
`ifdef STREAM_DEMUX_STATS_EN
    , .drop_cnt(dca)
`endif
  );

  stream_demux #(.N_OUT(3), .WIDTH(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(vb), .in_ready(irb), .in_data(data),
    .in_sel(sb), .out_valid(ovb), .out_ready(rb), .out_data(odb), .sel_err(errb)
`ifdef STREAM_DEMUX_STATS_EN
    , .drop_cnt(dcb)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic bit exp_ready(input int k, input int n, input int sel, input logic [3:0] rdy);
    if (sel >= n) return 1'b1;
    return !m_full[k][sel] || rdy[sel];
  endfunction

  function automatic logic [31:0] exp_valid(input int k, input int n);
    logic [31:0] v = '0;
    for (int i = 0; i < n; i++) v[i] = m_full[k][i];
    return v;
  endfunction

  function automatic logic [31:0] exp_data(input int k, input int n);
    logic [31:0] v = '0;
    for (int i = 0; i < n; i++) v[i*8 +: 8] = m_data[k][i];
    return v;
  endfunction

  // Apply one clock of transfer rules to instance k of the model.
  task automatic model_tick(input int k, input int n, input bit v, input int sel,
                            input logic [3:0] rdy, input logic [7:0] d);
    bit acc;
    acc = v && exp_ready(k, n, sel, rdy);
    for (int i = 0; i < n; i++) begin
      if (acc && sel == i) begin
        m_full[k][i] = 1'b1;
        m_data[k][i] = d;
      end else if (m_full[k][i] && rdy[i]) begin
        m_full[k][i] = 1'b0;
      end
    end
    if (acc && sel >= n) begin
      m_err[k] = 1'b1;
      if (m_drop[k] < 65535) m_drop[k]++;
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 4; i++) begin
        m_full[k][i] = 1'b0;
        m_data[k][i] = 8'h00;
      end
      m_err[k]  = 1'b0;
      m_drop[k] = 0;
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ":ova"}, 32'(ova), exp_valid(0, 4));
    chk({tag, ":oda"}, 32'(oda), exp_data(0, 4));
    chk({tag, ":erra"}, 32'(erra), 32'(m_err[0]));
    chk({tag, ":ovb"}, 32'(ovb), exp_valid(1, 3));
    chk({tag, ":odb"}, 32'(odb), exp_data(1, 3));
    chk({tag, ":errb"}, 32'(errb), 32'(m_err[1]));
`ifdef STREAM_DEMUX_STATS_EN
    chk({tag, ":dca"}, 32'(dca), 32'(m_drop[0]));
    chk({tag, ":dcb"}, 32'(dcb), 32'(m_drop[1]));
`endif
  endtask

  // One cycle: drive at posedge+1, check in_ready mid-cycle, check state after edge.
  task automatic step(input string tag, input logic v0, input logic [1:0] s0, input logic [3:0] r0,
                      input logic v1, input logic [1:0] s1, input logic [2:0] r1,
                      input logic [7:0] d);
    va = v0; sa = s0; ra = r0; vb = v1; sb = s1; rb = r1; data = d;
    #4;
    chk({tag, ":ira"}, 32'(ira), 32'(exp_ready(0, 4, int'(s0), r0)));
    chk({tag, ":irb"}, 32'(irb), 32'(exp_ready(1, 3, int'(s1), {1'b0, r1})));
    @(posedge clk);
    model_tick(0, 4, v0, int'(s0), r0, d);
    model_tick(1, 3, v1, int'(s1), {1'b0, r1}, d);
    #1;
    check_outputs(tag);
  endtask

  initial begin
    rst_n = 1'b0;
    va = 1'b0; vb = 1'b0; sa = 2'd0; sb = 2'd0; ra = 4'd0; rb = 3'd0; data = 8'h00;
    model_reset();
    #2;
    chk("rst:ira", 32'(ira), 32'd0);
    chk("rst:irb", 32'(irb), 32'd0);
    check_outputs("rst");
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Idle after reset: channel 0 is ready, nothing valid.
    step("idle", 1'b0, 2'd0, 4'b0000, 1'b0, 2'd0, 3'b000, 8'h00);
    // First beat to channel 2 with every consumer stalled.
    step("a5", 1'b1, 2'd2, 4'b0000, 1'b1, 2'd2, 3'b000, 8'hA5);
    // Second beat to the full, stalled channel 2 must be refused.
    step("blk", 1'b1, 2'd2, 4'b0000, 1'b1, 2'd2, 3'b000, 8'h5A);
    // Another channel still accepts.
    step("3c", 1'b1, 2'd1, 4'b0000, 1'b1, 2'd1, 3'b000, 8'h3C);
    // Fill channel 0, then pop and push it in the same cycle.
    step("fill0", 1'b1, 2'd0, 4'b0000, 1'b1, 2'd0, 3'b000, 8'h77);
    step("pp11", 1'b1, 2'd0, 4'b0001, 1'b1, 2'd0, 3'b001, 8'h11);
    // Stream 0..9 into channel 0 at full rate, one beat per cycle.
    for (int i = 0; i < 10; i++) begin
      step("strm", 1'b1, 2'd0, 4'b0001, 1'b1, 2'd0, 3'b001, 8'(i));
    end
    // Illegal select on the 3-channel instance: accepted, dropped, sticky error.
    step("ill", 1'b0, 2'd0, 4'b0000, 1'b1, 2'd3, 3'b000, 8'hEE);
    step("ill2", 1'b0, 2'd0, 4'b0000, 1'b1, 2'd3, 3'b000, 8'hEF);
    step("stk", 1'b0, 2'd0, 4'b0000, 1'b0, 2'd0, 3'b000, 8'h00);

    // Asynchronous reset mid-cycle with channels full.
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("mrst:ira", 32'(ira), 32'd0);
    chk("mrst:irb", 32'(irb), 32'd0);
    check_outputs("mrst");
    @(posedge clk);
    #1 rst_n = 1'b1;
    step("post", 1'b0, 2'd1, 4'b1111, 1'b0, 2'd1, 3'b111, 8'h00);

    // Randomized traffic on both instances.
    for (int i = 0; i < 300; i++) begin
      step("rnd", 1'($urandom), 2'($urandom_range(0, 3)), 4'($urandom),
           1'($urandom), 2'($urandom_range(0, 3)), 3'($urandom), 8'($urandom));
    end

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
